// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART.
// Status register layout and serialiser states.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_DIV_LSB = 32;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_uart_tx.sv
// SRAM-port UART transmitter: FIFO-buffered 8N1, LSB first.
// One 64-bit status/control register behind the crossbar.
module sram_uart_tx
  import uart_pkg::*;
#(
  parameter int          LEN_ADDR   = 64,
  parameter int          LEN_DATA   = 64,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] DIV_RESET  = 32'd868
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_ADDR-1:0] addra,
  input  logic [63:0]         dina,
  output logic [63:0]         douta,
  input  logic                ena,
  input  logic [7:0]          wea,
  output logic                txd,
  output logic                tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic [7:0]    f_dout;
  logic          f_full;
  logic          f_empty;
  logic [CW-1:0] f_count;

  logic          ovf;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   div_reg;
  logic [31:0]   eff_div;
  logic [63:0]   status;

  uart_state_t   state, state_n;
  logic [31:0]   baud_cnt, baud_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [31:0]   div_lat, div_n;
  logic          txd_n;
  logic          load;

  logic          unused_bits;
  assign unused_bits = ^{addra, dina[31:9], wea[3:2]};

  assign push    = ena && wea[0];
  assign ovf_set = push && f_full && !pop;
  assign ovf_clr = ena && wea[1] && dina[8];
  assign eff_div = (div_reg < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div_reg;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (dina[7:0]),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = f_full;
    status[ST_EMPTY]            = f_empty;
    status[ST_BUSY]             = (state != IDLE);
    status[ST_OVF]              = ovf;
    status[ST_CNT_LSB +: CW]    = f_count;
    status[ST_DIV_LSB +: 32]    = div_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      douta   <= '0;
      ovf     <= 1'b0;
      div_reg <= DIV_RESET;
    end else begin
      if (ena) begin
        douta <= status;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (ena && (&wea[7:4])) begin
        div_reg <= dina[63:32];
      end
    end
  end

  // A new frame may start from IDLE or straight out of STOP
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    idx_n   = bit_idx;
    shreg_n = shreg;
    div_n   = div_lat;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        load = !f_empty;
      end
      START: begin
        if (baud_cnt == '0) begin
          state_n = DATA;
          idx_n   = 3'd0;
          baud_n  = div_lat - 32'd1;
        end else begin
          baud_n  = baud_cnt - 32'd1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_n = div_lat - 32'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt - 32'd1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          load    = !f_empty;
          state_n = IDLE;
        end else begin
          baud_n  = baud_cnt - 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shreg_n = f_dout;
      div_n   = eff_div;
      baud_n  = eff_div - 32'd1;
      state_n = START;
    end
  end

  always_comb begin
    txd_n = 1'b1;
    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[idx_n];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      div_lat  <= DIV_RESET;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shreg    <= shreg_n;
      div_lat  <= div_n;
      txd      <= txd_n;
      tx_busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_sram_uart_tx.sv
// Directed bench for sram_uart_tx: status map, framing,
// back-to-back frames, overflow and reset abort.
module tb_sram_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta;
  logic        ena;
  logic [7:0]  wea;
  logic        txd;
  logic        tx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s       = 0;

  sram_uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .ena     (ena),
    .wea     (wea),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_status(input string tag,
                             input logic [63:0] exp);
    ena = 1'b1;
    wea = 8'h00;
    tick();
    ena = 1'b0;
    check(tag, douta, exp);
  endtask

  // Checks txd over one whole frame, starting at its first cycle
  task automatic frame(input logic [7:0] b, input int div);
    logic e;
    check("busy_in_frame", 64'(tx_busy), 64'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      e = 1'b0;
      else if (c == 9) e = 1'b1;
      else             e = b[c-1];
      for (int k = 0; k < div; k++) begin
        check($sformatf("txd_%02h_c%0d_k%0d", b, c, k),
              64'(txd), 64'(e));
        tick();
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 8'h00;
    dina  = '0;
    addra = 64'h6000_0000;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_douta", douta, 64'd0);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_busy", 64'(tx_busy), 64'd0);
    read_status("rst_status", 64'h0000_0364_0000_0002);
    check("idle_txd", 64'(txd), 64'd1);

    // single frame at divisor 4
    ena  = 1'b1;
    wea  = 8'hF0;
    dina = {32'd4, 32'd0};
    tick();
    wea  = 8'h01;
    dina = 64'hA5;
    tick();
    ena = 1'b0;
    wea = 8'h00;
    check("push_edge_txd", 64'(txd), 64'd1);
    tick();
    frame(8'hA5, 4);
    check("a5_busy_drop", 64'(tx_busy), 64'd0);
    check("a5_txd_idle", 64'(txd), 64'd1);

    // back-to-back frames
    ena  = 1'b1;
    wea  = 8'h01;
    dina = 64'h55;
    tick();
    dina = 64'h0F;
    tick();
    ena = 1'b0;
    wea = 8'h00;
    frame(8'h55, 4);
    frame(8'h0F, 4);
    check("b2b_busy_drop", 64'(tx_busy), 64'd0);
    read_status("b2b_status", 64'h0000_0004_0000_0002);

    // partial divisor write is ignored
    ena  = 1'b1;
    wea  = 8'h70;
    dina = {32'd9, 32'd0};
    tick();
    read_status("partial_div", 64'h0000_0004_0000_0002);

    // divisor 1 runs at the minimum of 2
    ena  = 1'b1;
    wea  = 8'hF0;
    dina = {32'd1, 32'd0};
    tick();
    wea  = 8'h01;
    dina = 64'h3C;
    tick();
    ena = 1'b0;
    wea = 8'h00;
    tick();
    frame(8'h3C, 2);
    check("min_div_busy", 64'(tx_busy), 64'd0);

    // fill FIFO and overflow at divisor 100
    ena  = 1'b1;
    wea  = 8'hF0;
    dina = {32'd100, 32'd0};
    tick();
    wea = 8'h01;
    for (int i = 0; i < 17; i++) begin
      dina = 64'(8'h10 + i);
      tick();
      if (i == 1) s = cyc;
    end
    ena = 1'b0;
    wea = 8'h00;
    read_status("fill_status", 64'h0000_0064_0000_1005);
    ena  = 1'b1;
    wea  = 8'h01;
    dina = 64'h99;
    tick();
    read_status("ovf_set", 64'h0000_0064_0000_100D);
    ena  = 1'b1;
    wea  = 8'h02;
    dina = 64'h100;
    tick();
    read_status("ovf_clr", 64'h0000_0064_0000_1005);
    ena  = 1'b1;
    wea  = 8'h03;
    dina = 64'h1AB;
    tick();
    read_status("ovf_set_wins", 64'h0000_0064_0000_100D);
    ena  = 1'b1;
    wea  = 8'h02;
    dina = 64'h100;
    tick();
    read_status("ovf_clr2", 64'h0000_0064_0000_1005);

    // push lands on the STOP-end pop
    while (cyc < s + 999) tick();
    check("stop_last_txd", 64'(txd), 64'd1);
    ena  = 1'b1;
    wea  = 8'h01;
    dina = 64'h77;
    tick();
    ena = 1'b0;
    wea = 8'h00;
    check("next_start_txd", 64'(txd), 64'd0);
    read_status("full_pushpop", 64'h0000_0064_0000_1005);

    // reset in the middle of data bit 1 of byte 0x11
    while (cyc < s + 1250) tick();
    check("pre_rst_txd", 64'(txd), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_txd", 64'(txd), 64'd1);
    check("abort_busy", 64'(tx_busy), 64'd0);
    check("abort_douta", douta, 64'd0);
    read_status("abort_status", 64'h0000_0364_0000_0002);
    for (int i = 0; i < 60; i++) begin
      check($sformatf("quiet_%0d", i), 64'(txd), 64'd1);
      tick();
    end
    check("quiet_busy", 64'(tx_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_uart_tx.md
Name: sram_uart_tx

Overview:
- Memory-mapped UART transmitter that sits behind the data-side crossbar slave port mapped at 0x60000000.
- Accepts bytes through the same single-port SRAM-style interface as the data memory: addra/dina/douta/ena/wea, 1-cycle registered read.
- Buffers bytes in a TX FIFO and serialises them 8N1, LSB first, onto txd.

Parameters:
- LEN_ADDR, 64, address width (only used to size addra; the whole port is one 64-bit register).
- LEN_DATA, 64, data width; fixed at 64 (register map below assumes it).
- FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
- DIV_RESET, 868, reset value of the baud divisor in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- addra  input  LEN_ADDR  byte address; ignored because the crossbar has already decoded it.
- dina  input  64  write data.
- douta  output  64  registered status/read data.
- ena  input  1  access enable.
- wea  input  8  byte write enables.
- txd  output  1  serial line, idle high.
- tx_busy  output  1  high while the serialiser is not IDLE.

Behaviour:
- Reset values: douta=0, txd=1, tx_busy=0, FIFO empty, overflow=0, divisor=DIV_RESET, FSM=IDLE, bit counter and baud counter 0. Reset mid-frame aborts the frame: txd=1 after that edge and the FIFO is flushed.
- Register map for read, douta latched on the edge where ena=1:
  - [0] full
  - [1] empty
  - [2] busy
  - [3] overflow
  - [12:8] FIFO count (zero-extended)
  - [63:32] divisor
  - all other bits 0
- douta holds its value when ena=0. Read-before-write: with ena=1 and wea!=0, douta returns the status from before the write.
- Writes occur only when ena=1.
  - wea[0]: push dina[7:0]. If the FIFO is full and no pop happens that same cycle, the byte is dropped and overflow is set (sticky).
  - wea[1] with dina[8]=1: clear overflow. A set caused by a push in the same cycle wins over the clear.
  - wea[7:4] all set: divisor <= dina[63:32]. The effective divisor is max(divisor,2). It is sampled only when a frame starts; a change mid-frame does not affect the current frame.
  - Partial wea[7:4] is ignored.
- FIFO: simultaneous push and pop when full is accepted, and count stays full. Push and pop when count==1 keeps count at 1. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop into shreg, latch the divisor, load baud counter=div-1, go to START.
  - START: txd=0 for div cycles, then go to DATA with bit index 0.
  - DATA: txd=shreg[idx] for div cycles per bit, idx 0..7, then go to STOP.
  - STOP: txd=1 for div cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- txd is a registered output.
- Timing: a byte written at edge t into an empty FIFO while IDLE gives txd=0 from edge t+1. A frame lasts exactly 10*div cycles.
- tx_busy = (state!=IDLE), registered alongside txd.

Decomposition:
- Package uart_pkg holds:
  - the uart_state_t enum (IDLE/START/DATA/STOP);
  - status bit-index constants ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_OVF=3, ST_CNT_LSB=8, ST_DIV_LSB=32;
  - DIV_MIN=2.
- One sub-module, sync_fifo: a parameterised width/depth FIFO with push/pop/full/empty/count and synchronous active-high reset. It is reusable later for an RX path.

Test Plan:
- Reset, then read status (ena=1, wea=0): next-cycle douta=0x0000_0364_0000_0002 (divisor 868, empty=1); txd=1 throughout.
- Write divisor 4 (wea=0xF0, dina[63:32]=4), then push 0xA5 (wea=0x01): txd goes low one cycle after the push edge. The following bit cells, 4 cycles each, are start 0, data 1,0,1,0,0,1,0,1, stop 1. tx_busy drops 40 cycles after it rises.
- Push 0x55 and 0x0F back-to-back, div=4: frames are contiguous (80 cycles) with no idle cycle between stop and start; empty=1 afterwards.
- Push 17 bytes with div=100 while the first is transmitting: the first pops immediately and 16 fill the FIFO, giving full=1, count=16, overflow=0. The 18th push is dropped and sets overflow=1. Writing wea=0x02 with dina[8]=1 clears overflow.
- Full FIFO with push coinciding with the STOP-end pop: the push is accepted, count stays 16, and overflow stays 0.
- Assert rst mid-DATA bit: txd=1 at the next edge, status reads 0x0000_0364_0000_0002, and no residual frame follows.
